ps2_host: RTL and testbench

PS2_HOST -- requirements
Module: ps2_host

---
 rtl/ps2_host.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host.sv
// PS/2 host transmitter: arbitrates two requesters and sends one command
// byte per grant to the device, reporting the device ACK bit as ack/nak.
// Ports: clock/reset (async, active low), ce tick enable, ps2ci/ps2di pad
// inputs, ps2co/ps2do open-drain drives (1 = release), req/d0/d1 requests
// and bytes, busy, and per-requester one-cycle ack/nak pulses.
module ps2_host #(
    parameter int INHIBIT = 100,
    parameter int TIMEOUT = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2ci,
    input  logic       ps2di,
    output logic       ps2co,
    output logic       ps2do,
    input  logic [1:0] req,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    output logic       busy,
    output logic [1:0] ack,
    output logic [1:0] nak
);

    localparam int IW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] ILAST = IW'(INHIBIT - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACKW,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    filt_q, filt_d;
    logic          fclk_q, fclk_d;
    logic          di_q, di_d;
    logic          co_q, co_d;
    logic          do_q, do_d;
    logic          busy_q, busy_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    nak_q, nak_d;
    logic          idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fall;

    // A device clock edge counts once the filtered clock is high and
    // the last 8 ce samples are all low.
    assign fall = fclk_q && (filt_q == 8'h00);

    always_comb begin
        filt_d = filt_q;
        fclk_d = fclk_q;
        di_d   = di_q;
        if (ce) begin
            filt_d = {filt_q[6:0], ps2ci};
            di_d   = ps2di;
            if (filt_q == 8'hFF) begin
                fclk_d = 1'b1;
            end else if (filt_q == 8'h00) begin
                fclk_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        co_d    = co_q;
        do_d    = do_q;
        busy_d  = busy_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        icnt_d  = icnt_q;
        bcnt_d  = bcnt_q;
        tmo_d   = tmo_q;
        ack_d   = 2'b00;
        nak_d   = 2'b00;
        if (ce) begin
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        idx_d   = ~req[0];
                        byte_d  = req[0] ? d0 : d1;
                        icnt_d  = '0;
                        bcnt_d  = '0;
                        tmo_d   = '0;
                        co_d    = 1'b0;
                        do_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (icnt_q == ILAST) begin
                        co_d    = 1'b1;
                        do_d    = 1'b0;
                        tmo_d   = '0;
                        state_d = S_RTS;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
                S_RTS, S_SEND, S_ACKW: begin
                    tmo_d = (tmo_q == TMAX) ? tmo_q : tmo_q + 1'b1;
                    if (tmo_q >= TLAST) begin
                        co_d         = 1'b1;
                        do_d         = 1'b1;
                        nak_d[idx_q] = 1'b1;
                        state_d      = S_DONE;
                    end else if (state_q == S_RTS) begin
                        state_d = S_SEND;
                    end else if (fall && state_q == S_SEND) begin
                        bcnt_d = bcnt_q + 4'd1;
                        if (bcnt_q < 4'd8) begin
                            do_d = byte_q[bcnt_q[2:0]];
                        end else if (bcnt_q == 4'd8) begin
                            do_d = ~^byte_q;
                        end else begin
                            do_d    = 1'b1;
                            state_d = S_ACKW;
                        end
                    end else if (fall) begin
                        if (di_q) begin
                            nak_d[idx_q] = 1'b1;
                        end else begin
                            ack_d[idx_q] = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    co_d    = 1'b1;
                    do_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            filt_q  <= 8'hFF;
            fclk_q  <= 1'b1;
            di_q    <= 1'b1;
            co_q    <= 1'b1;
            do_q    <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 2'b00;
            nak_q   <= 2'b00;
            idx_q   <= 1'b0;
            byte_q  <= 8'h00;
            icnt_q  <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            fclk_q  <= fclk_d;
            di_q    <= di_d;
            co_q    <= co_d;
            do_q    <= do_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            nak_q   <= nak_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            icnt_q  <= icnt_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ps2co = co_q;
    assign ps2do = do_q;
    assign busy  = busy_q;
    assign ack   = ack_q;
    assign nak   = nak_q;

endmodule

// File: tb/tb_ps2_host.sv
// Bench for ps2_host: a PS/2 device model clocks frames out of the host
// and compares them with frames built from the byte and parity rule.
module tb_ps2_host;

    localparam int INH = 100;
    localparam int TMO = 2000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b1;
    logic       ps2ci, ps2di, ps2co, ps2do, busy;
    logic [1:0] req = 2'b00;
    logic [1:0] ack, nak;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         acnt[2];
    int         ncnt[2];

    // Open-drain bus: either side can pull a line low.
    assign ps2ci = dev_clk & ps2co;
    assign ps2di = dev_dat & ps2do;

    always #5 clock = ~clock;

    ps2_host #(.INHIBIT(INH), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .ce(ce),
        .ps2ci(ps2ci), .ps2di(ps2di),
        .ps2co(ps2co), .ps2do(ps2do),
        .req(req), .d0(d0), .d1(d1),
        .busy(busy), .ack(ack), .nak(nak)
    );

    // Count high cycles of each pulse output.
    initial begin
        acnt[0] = 0; acnt[1] = 0; ncnt[0] = 0; ncnt[1] = 0;
    end
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (ack[i] === 1'b1) acnt[i] <= acnt[i] + 1;
            if (nak[i] === 1'b1) ncnt[i] <= ncnt[i] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Frame bits in transmit order: 8 data LSB first, odd parity, stop.
    function automatic logic [9:0] frame(input logic [7:0] b);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        p = (ones % 2 == 0);
        return {1'b1, p, b};
    endfunction

    task automatic xfer(input int idx, input logic [7:0] b,
                        input logic dnak, input bit glitch,
                        input int abort_at, input bit scramble);
        int         n;
        int         a0[2];
        int         n0[2];
        logic [9:0] rx;
        bit         seen;
        a0 = acnt;
        n0 = ncnt;
        n = 0;
        while (ps2co !== 1'b0 && n < 20) begin tick(1); n++; end
        chk("grant_co_low", ps2co, 0);
        chk("grant_busy", busy, 1);
        n = 0;
        while (ps2co === 1'b0 && n < 1000) begin tick(1); n++; end
        chk("inhibit_len", n, INH);
        chk("start_bit", ps2do, 0);
        if (scramble) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
        end
        tick(30);
        rx = '0;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            tick(20);
            dev_clk = 1'b1;
            tick(1);
            rx[k-1] = ps2do;
            if (glitch && k == 4) begin
                tick(5);
                dev_clk = 1'b0;
                tick(4);
                dev_clk = 1'b1;
                tick(10);
            end else begin
                tick(19);
            end
            if (abort_at == k) begin
                chk("pre_abort_do", ps2do, 0);
                #2 reset = 1'b0;
                #1;
                chk("abort_co", ps2co, 1);
                chk("abort_do", ps2do, 1);
                chk("abort_busy", busy, 0);
                req = 2'b00;
                tick(3);
                reset = 1'b1;
                tick(40);
                chk("abort_no_resp",
                    acnt[0] + acnt[1] + ncnt[0] + ncnt[1]
                    - a0[0] - a0[1] - n0[0] - n0[1], 0);
                return;
            end
        end
        chk("frame", rx, frame(b));
        dev_dat = dnak;
        dev_clk = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick(1);
            if ((ack | nak) !== 2'b00) seen = 1'b1;
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        req[idx] = 1'b0;
        chk("resp_seen", seen, 1);
        tick(1);
        chk("idle_gap", busy, 0);
        chk("ack_cnt", acnt[idx] - a0[idx], dnak ? 0 : 1);
        chk("nak_cnt", ncnt[idx] - n0[idx], dnak ? 1 : 0);
        chk("other_idx",
            acnt[1-idx] - a0[1-idx] + ncnt[1-idx] - n0[1-idx], 0);
    endtask

    initial begin
        int         m;
        int         idx;
        logic [7:0] b;
        logic       dn;

        tick(2);
        chk("rst_co", ps2co, 1);
        chk("rst_do", ps2do, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_nak", nak, 0);
        reset = 1'b1;
        tick(12);

        // Request held while ce is low must not be granted.
        d1 = 8'hED;
        req = 2'b10;
        ce = 1'b0;
        tick(10);
        chk("ce_freeze_co", ps2co, 1);
        chk("ce_freeze_busy", busy, 0);
        ce = 1'b1;
        xfer(1, 8'hED, 1'b0, 0, 0, 1);
        tick(12);

        d0 = 8'hFF;
        d1 = 8'h01;
        req = 2'b11;
        xfer(0, 8'hFF, 1'b0, 0, 0, 0);
        xfer(1, 8'h01, 1'b0, 0, 0, 0);
        tick(12);

        d0 = 8'h00;
        req = 2'b01;
        xfer(0, 8'h00, 1'b1, 0, 0, 1);
        tick(12);

        b = 8'($urandom);
        d1 = b;
        req = 2'b10;
        xfer(1, b, 1'b0, 1, 0, 1);
        tick(12);

        for (int r = 0; r < 6; r++) begin
            idx = int'($urandom_range(0, 1));
            b = 8'($urandom);
            dn = 1'($urandom_range(0, 1));
            if (idx == 0) d0 = b; else d1 = b;
            req[idx] = 1'b1;
            xfer(idx, b, dn, 0, 0, 1);
            tick(12);
        end

        // Device never clocks.
        d0 = 8'($urandom);
        req = 2'b01;
        m = 0;
        while (ps2co !== 1'b0 && m < 20) begin tick(1); m++; end
        m = 0;
        while (ps2co === 1'b0 && m < 1000) begin tick(1); m++; end
        m = 0;
        while (nak === 2'b00 && m < TMO + 50) begin tick(1); m++; end
        chk("timeout_len", m, TMO);
        chk("timeout_nak", nak, 2'b01);
        chk("timeout_ack", ack, 2'b00);
        chk("timeout_co", ps2co, 1);
        chk("timeout_do", ps2do, 1);
        req = 2'b00;
        tick(1);
        chk("timeout_idle", busy, 0);
        tick(3);
        chk("timeout_stay", ps2co, 1);
        tick(12);

        b = 8'($urandom) & 8'hEF;
        d1 = b;
        req = 2'b10;
        xfer(1, b, 1'b0, 0, 5, 1);
        tick(12);

        b = 8'($urandom);
        d0 = b;
        req = 2'b01;
        xfer(0, b, 1'b0, 0, 0, 1);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
